// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: configurable data/parity/stop bits,
// 3-sample majority vote, start-glitch rejection, error flags.
// Ports: clk, rst (sync, active-high), rx (async serial in, idles high),
//   data/valid/ready (held word + handshake), parity_err, frame_err,
//   overrun (sticky until next handshake), busy (not IDLE).
module uart_rx_os #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = $clog2(OVERSAMPLE);

   localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] S_V2   = SW'(OVERSAMPLE / 2 + 1);
   localparam logic [3:0]    B_LAST = 4'(DATA_BITS - 1);
   localparam logic          P_LAST = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PAR, STOP, BREAK
   } state_t;

   state_t               state;
   logic                 rx_m, rx_s;
   logic [TW-1:0]        tcnt;
   logic [SW-1:0]        s;
   logic                 smp0, smp1;
   logic [3:0]           bcnt;
   logic                 scnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 perr_r, ferr_r;

   logic tick, smp3, bit_end, vote, last_stop, par_x, hs;

   assign tick      = (state != IDLE) && (tcnt == T_LAST);
   assign smp3      = tick && (s == S_V2);
   assign bit_end   = tick && (s == S_LAST);
   // third sample taken live from rx_s so the vote is usable on its tick
   assign vote      = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
   assign last_stop = (scnt == P_LAST);
   assign par_x     = (^shreg) ^ vote;
   assign hs        = valid && ready;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m       <= 1'b1;
         rx_s       <= 1'b1;
         state      <= IDLE;
         tcnt       <= '0;
         s          <= '0;
         smp0       <= 1'b0;
         smp1       <= 1'b0;
         bcnt       <= '0;
         scnt       <= 1'b0;
         shreg      <= '0;
         perr_r     <= 1'b0;
         ferr_r     <= 1'b0;
         data       <= '0;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;

         if (state == IDLE) begin
            tcnt <= '0;
            s    <= '0;
         end else begin
            tcnt <= tick ? '0 : tcnt + 1'b1;
            if (tick)
               s <= (s == S_LAST) ? '0 : s + 1'b1;
         end

         if (tick && s == S_V0) smp0 <= rx_s;
         if (tick && s == S_V1) smp1 <= rx_s;

         if (hs) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
         end

         unique case (state)
            IDLE: begin
               if (!rx_s) begin
                  state  <= START;
                  bcnt   <= '0;
                  scnt   <= 1'b0;
                  perr_r <= 1'b0;
                  ferr_r <= 1'b0;
               end
            end
            START: begin
               if (smp3 && vote)
                  state <= IDLE;
               else if (bit_end)
                  state <= DATA;
            end
            DATA: begin
               if (smp3)
                  shreg <= {vote, shreg[DATA_BITS-1:1]};
               if (bit_end) begin
                  if (bcnt == B_LAST) begin
                     bcnt  <= '0;
                     state <= (PARITY != 0) ? PAR : STOP;
                  end else begin
                     bcnt <= bcnt + 1'b1;
                  end
               end
            end
            PAR: begin
               if (smp3)
                  perr_r <= (PARITY == 1) ? ~par_x : par_x;
               if (bit_end)
                  state <= STOP;
            end
            STOP: begin
               if (smp3 && !vote)
                  ferr_r <= 1'b1;
               // final stop bit completes mid-bit to allow early resync
               if (smp3 && last_stop) begin
                  data       <= shreg;
                  parity_err <= perr_r;
                  frame_err  <= ferr_r | ~vote;
                  valid      <= 1'b1;
                  if (valid && !ready)
                     overrun <= 1'b1;
                  state <= vote ? IDLE : BREAK;
               end else if (bit_end) begin
                  scnt <= scnt + 1'b1;
               end
            end
            BREAK: begin
               if (rx_s)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: three instances cover 8N1,
// 8E1 and 7N2 framing; 160 clocks per bit (TICK_DIV=10, OS=16).
module tb_uart_rx_os;

   localparam int CF  = 1600000;
   localparam int BR  = 10000;
   localparam int OS  = 16;
   localparam int BIT = 160;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
   logic rdy0 = 1'b1, rdy1 = 1'b1, rdy2 = 1'b1;

   logic [7:0] d0, d1;
   logic [6:0] d2;
   logic v0, v1, v2;
   logic pe0, pe1, pe2;
   logic fe0, fe1, fe2;
   logic ov0, ov1, ov2;
   logic bz0, bz1, bz2;

   always #5 clk = ~clk;

   uart_rx_os #(.CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS),
      .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
      .clk(clk), .rst(rst), .rx(rx0), .data(d0), .valid(v0),
      .ready(rdy0), .parity_err(pe0), .frame_err(fe0),
      .overrun(ov0), .busy(bz0));

   uart_rx_os #(.CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS),
      .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
      .clk(clk), .rst(rst), .rx(rx1), .data(d1), .valid(v1),
      .ready(rdy1), .parity_err(pe1), .frame_err(fe1),
      .overrun(ov1), .busy(bz1));

   uart_rx_os #(.CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS),
      .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u2 (
      .clk(clk), .rst(rst), .rx(rx2), .data(d2), .valid(v2),
      .ready(rdy2), .parity_err(pe2), .frame_err(fe2),
      .overrun(ov2), .busy(bz2));

   int tests = 0;
   int fails = 0;

   int         hs_cnt[3] = '{0, 0, 0};
   logic [8:0] cap_d[3];
   logic       cap_p[3];
   logic       cap_f[3];

   always @(negedge clk) begin
      if (v0 && rdy0) begin
         hs_cnt[0]++; cap_d[0] = {1'b0, d0}; cap_p[0] = pe0; cap_f[0] = fe0;
      end
      if (v1 && rdy1) begin
         hs_cnt[1]++; cap_d[1] = {1'b0, d1}; cap_p[1] = pe1; cap_f[1] = fe1;
      end
      if (v2 && rdy2) begin
         hs_cnt[2]++; cap_d[2] = {2'b0, d2}; cap_p[2] = pe2; cap_f[2] = fe2;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_rx(input int sel, input logic b);
      case (sel)
         0: rx0 = b;
         1: rx1 = b;
         default: rx2 = b;
      endcase
   endtask

   task automatic hold(input int sel, input logic b, input int n);
      set_rx(sel, b);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input int sel, input logic [8:0] w,
                            input logic pb);
      int nb;
      nb = (sel == 2) ? 7 : 8;
      hold(sel, 1'b0, BIT);
      for (int i = 0; i < nb; i++) hold(sel, w[i], BIT);
      if (sel == 1) hold(sel, pb, BIT);
   endtask

   task automatic send(input int sel, input logic [8:0] w,
                       input logic pb, input logic [1:0] st);
      send_bits(sel, w, pb);
      hold(sel, st[0], BIT);
      if (sel == 2) hold(sel, st[1], BIT);
      hold(sel, 1'b1, BIT);
   endtask

   typedef struct {
      int         sel;
      logic [8:0] w;
      logic       pb;
      logic [1:0] st;
      logic [8:0] ed;
      logic       ep;
      logic       ef;
   } vec_t;

   vec_t vt[11];

   initial begin
      int base;

      vt[0]  = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
      vt[1]  = '{0, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0};
      vt[2]  = '{0, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0};
      vt[3]  = '{1, 9'h03C, 1'b1, 2'b11, 9'h03C, 1'b1, 1'b0};
      vt[4]  = '{1, 9'h03C, 1'b0, 2'b11, 9'h03C, 1'b0, 1'b0};
      vt[5]  = '{1, 9'h001, 1'b1, 2'b11, 9'h001, 1'b0, 1'b0};
      vt[6]  = '{1, 9'h001, 1'b0, 2'b11, 9'h001, 1'b1, 1'b0};
      vt[7]  = '{2, 9'h055, 1'b0, 2'b11, 9'h055, 1'b0, 1'b0};
      vt[8]  = '{2, 9'h033, 1'b0, 2'b10, 9'h033, 1'b0, 1'b1};
      vt[9]  = '{2, 9'h07F, 1'b0, 2'b01, 9'h07F, 1'b0, 1'b1};
      vt[10] = '{1, 9'h0C3, 1'b0, 2'b00, 9'h0C3, 1'b0, 1'b1};

      repeat (5) @(negedge clk);
      chk("rst valid0", v0, 0);
      chk("rst data0", d0, 0);
      chk("rst busy0", bz0, 0);
      chk("rst ovr0", ov0, 0);
      chk("rst valid2", v2, 0);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      for (int i = 0; i < 11; i++) begin
         base = hs_cnt[vt[i].sel];
         send(vt[i].sel, vt[i].w, vt[i].pb, vt[i].st);
         chk($sformatf("v%0d count", i), hs_cnt[vt[i].sel] - base, 1);
         chk($sformatf("v%0d data", i), cap_d[vt[i].sel], vt[i].ed);
         chk($sformatf("v%0d perr", i), cap_p[vt[i].sel], vt[i].ep);
         chk($sformatf("v%0d ferr", i), cap_f[vt[i].sel], vt[i].ef);
      end

      base = hs_cnt[0];
      hold(0, 1'b0, 40);
      chk("glitch busy", bz0, 1);
      rx0 = 1'b1;
      for (int k = 0; k < BIT && bz0; k++) @(negedge clk);
      chk("glitch idle", bz0, 0);
      hold(0, 1'b1, BIT);
      chk("glitch count", hs_cnt[0] - base, 0);

      base = hs_cnt[0];
      send_bits(0, 9'h081, 1'b0);
      hold(0, 1'b0, BIT + 2000);
      chk("break busy", bz0, 1);
      hold(0, 1'b1, 2 * BIT);
      chk("break idle", bz0, 0);
      chk("break count", hs_cnt[0] - base, 1);
      chk("break data", cap_d[0], 9'h081);
      chk("break ferr", cap_f[0], 1);
      base = hs_cnt[0];
      send(0, 9'h042, 1'b0, 2'b11);
      chk("post count", hs_cnt[0] - base, 1);
      chk("post data", cap_d[0], 9'h042);
      chk("post ferr", cap_f[0], 0);

      rdy0 = 1'b0;
      send(0, 9'h011, 1'b0, 2'b11);
      chk("ovr1 valid", v0, 1);
      chk("ovr1 data", d0, 8'h11);
      chk("ovr1 flag", ov0, 0);
      send(0, 9'h022, 1'b0, 2'b11);
      chk("ovr2 valid", v0, 1);
      chk("ovr2 data", d0, 8'h22);
      chk("ovr2 flag", ov0, 1);
      rdy0 = 1'b1;
      @(negedge clk);
      chk("ovr hs valid", v0, 0);
      chk("ovr hs flag", ov0, 0);

      rdy2 = 1'b0;
      send(2, 9'h02A, 1'b0, 2'b11);
      chk("pre-rst valid2", v2, 1);
      chk("pre-rst data2", d2, 7'h2A);
      hold(2, 1'b0, BIT);
      hold(2, 1'b0, BIT);
      hold(2, 1'b1, BIT);
      hold(2, 1'b0, BIT);
      chk("mid busy2", bz2, 1);
      rst = 1'b1;
      rx2 = 1'b1;
      @(negedge clk);
      chk("mid-rst valid2", v2, 0);
      chk("mid-rst data2", d2, 0);
      chk("mid-rst busy2", bz2, 0);
      chk("mid-rst perr2", pe2, 0);
      chk("mid-rst ferr2", fe2, 0);
      chk("mid-rst ovr2", ov2, 0);
      rst = 1'b0;
      rdy2 = 1'b1;
      hold(2, 1'b1, 2 * BIT);
      base = hs_cnt[2];
      send(2, 9'h05A, 1'b0, 2'b11);
      chk("5A count", hs_cnt[2] - base, 1);
      chk("5A data", cap_d[2], 9'h05A);
      chk("5A ferr", cap_f[2], 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
